scr1_pipe_wb_arb: RTL and testbench

//  Write-back arbiter and load scoreboard feeding the single MPRF write port.

---
 rtl/scr1_pipe_wb_arb_if.sv | 45 ++++
 rtl/scr1_pipe_wb_arb.sv | 137 +++++++++++++
 tb/tb_scr1_pipe_wb_arb.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_pipe_wb_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scr1_pipe_wb_arb_if : EXU/LSU/MPRF-side bundle of the write-back arbiter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface scr1_pipe_wb_arb_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              exu_wb_req;
    logic [ADDR_W-1:0] exu_wb_addr;
    logic [XLEN-1:0]   exu_wb_data;
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_issue_addr;
    logic              ld_issue_rdy;
    logic              ld_ret_vld;
    logic [XLEN-1:0]   ld_ret_data;
    logic              ld_ret_err;
    logic [ADDR_W-1:0] hzd_rs1_addr;
    logic [ADDR_W-1:0] hzd_rs2_addr;
    logic [ADDR_W-1:0] hzd_rd_addr;
    logic              hzd_rs1;
    logic              hzd_rs2;
    logic              hzd_rd;
    logic              mprf_w_req;
    logic [ADDR_W-1:0] mprf_rd_addr;
    logic [XLEN-1:0]   mprf_rd_data;

    modport master (
        output exu_wb_req, exu_wb_addr, exu_wb_data,
        output ld_issue, ld_issue_addr, ld_ret_vld, ld_ret_data, ld_ret_err,
        output hzd_rs1_addr, hzd_rs2_addr, hzd_rd_addr,
        input  ld_issue_rdy, hzd_rs1, hzd_rs2, hzd_rd,
        input  mprf_w_req, mprf_rd_addr, mprf_rd_data
    );

    modport slave (
        input  exu_wb_req, exu_wb_addr, exu_wb_data,
        input  ld_issue, ld_issue_addr, ld_ret_vld, ld_ret_data, ld_ret_err,
        input  hzd_rs1_addr, hzd_rs2_addr, hzd_rd_addr,
        output ld_issue_rdy, hzd_rs1, hzd_rs2, hzd_rd,
        output mprf_w_req, mprf_rd_addr, mprf_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/scr1_pipe_wb_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scr1_pipe_wb_arb : MPRF write-back arbiter with in-order load scoreboard |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module scr1_pipe_wb_arb #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int LD_DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    scr1_pipe_wb_arb_if.slave  wb_if
);
    localparam int                PTR_W    = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int                CNT_W    = $clog2(LD_DEPTH + 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(LD_DEPTH - 1);

    logic [LD_DEPTH-1:0] valid_q;
    logic [LD_DEPTH-1:0] filled_q;
    logic [LD_DEPTH-1:0] err_q;
    logic [ADDR_W-1:0]   addr_q [LD_DEPTH];
    logic [XLEN-1:0]     data_q [LD_DEPTH];
    logic [PTR_W-1:0]    alloc_q, fill_q, retire_q;
    logic [CNT_W-1:0]    count_q, count_d;

    logic              w_alloc, w_fill_ok, w_fill, w_ret_head;
    logic              w_head_vld, w_head_filled, w_head_err, w_head_nowr;
    logic              w_retire, w_head_wr;
    logic [ADDR_W-1:0] w_head_addr;
    logic [XLEN-1:0]   w_head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit comes from the registered count only, so a same-cycle retire never frees a slot early.
    assign wb_if.ld_issue_rdy = (count_q < CNT_W'(LD_DEPTH));
    assign w_alloc   = wb_if.ld_issue & wb_if.ld_issue_rdy;
    assign w_fill_ok = valid_q[fill_q] & ~filled_q[fill_q];
    assign w_fill    = wb_if.ld_ret_vld & w_fill_ok;

    // A return landing on the unfilled head is visible to the retire path in the same cycle.
    assign w_ret_head    = w_fill & (fill_q == retire_q);
    assign w_head_vld    = valid_q[retire_q];
    assign w_head_addr   = addr_q[retire_q];
    assign w_head_filled = filled_q[retire_q] | w_ret_head;
    assign w_head_err    = filled_q[retire_q] ? err_q[retire_q]  : wb_if.ld_ret_err;
    assign w_head_data   = filled_q[retire_q] ? data_q[retire_q] : wb_if.ld_ret_data;
    assign w_head_nowr   = w_head_err | (w_head_addr == '0);
    assign w_retire      = w_head_vld & w_head_filled & (w_head_nowr | ~wb_if.exu_wb_req);
    assign w_head_wr     = w_retire & ~w_head_nowr;

    assign count_d = count_q + CNT_W'(w_alloc) - CNT_W'(w_retire);

    always_comb begin
        wb_if.mprf_w_req   = 1'b0;
        wb_if.mprf_rd_addr = '0;
        wb_if.mprf_rd_data = '0;
        if (wb_if.exu_wb_req) begin
            wb_if.mprf_w_req   = 1'b1;
            wb_if.mprf_rd_addr = wb_if.exu_wb_addr;
            wb_if.mprf_rd_data = wb_if.exu_wb_data;
        end else if (w_head_wr) begin
            wb_if.mprf_w_req   = 1'b1;
            wb_if.mprf_rd_addr = w_head_addr;
            wb_if.mprf_rd_data = w_head_data;
        end
    end

    always_comb begin
        wb_if.hzd_rs1 = 1'b0;
        wb_if.hzd_rs2 = 1'b0;
        wb_if.hzd_rd  = 1'b0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (valid_q[i]) begin
                if (addr_q[i] == wb_if.hzd_rs1_addr) wb_if.hzd_rs1 = 1'b1;
                if (addr_q[i] == wb_if.hzd_rs2_addr) wb_if.hzd_rs2 = 1'b1;
                if (addr_q[i] == wb_if.hzd_rd_addr)  wb_if.hzd_rd  = 1'b1;
            end
        end
        wb_if.hzd_rs1 = wb_if.hzd_rs1 & (wb_if.hzd_rs1_addr != '0);
        wb_if.hzd_rs2 = wb_if.hzd_rs2 & (wb_if.hzd_rs2_addr != '0);
        wb_if.hzd_rd  = wb_if.hzd_rd  & (wb_if.hzd_rd_addr  != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            filled_q <= '0;
            err_q    <= '0;
            alloc_q  <= '0;
            fill_q   <= '0;
            retire_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < LD_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (w_alloc) begin
                valid_q[alloc_q]  <= 1'b1;
                filled_q[alloc_q] <= 1'b0;
                err_q[alloc_q]    <= 1'b0;
                addr_q[alloc_q]   <= wb_if.ld_issue_addr;
                alloc_q           <= ptr_inc(alloc_q);
            end
            if (w_fill) begin
                filled_q[fill_q] <= 1'b1;
                err_q[fill_q]    <= wb_if.ld_ret_err;
                data_q[fill_q]   <= wb_if.ld_ret_data;
                fill_q           <= ptr_inc(fill_q);
            end
            // Retire last: a bypassed return must leave its slot empty, not filled.
            if (w_retire) begin
                valid_q[retire_q]  <= 1'b0;
                filled_q[retire_q] <= 1'b0;
                retire_q           <= ptr_inc(retire_q);
            end
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    a_wr_no_x: assert property (@(posedge clk) disable iff (!rst_n)
        wb_if.mprf_w_req |-> !$isunknown({wb_if.mprf_rd_addr, wb_if.mprf_rd_data}));
    a_issue_rdy: assert property (@(posedge clk) disable iff (!rst_n)
        !(wb_if.ld_issue && !wb_if.ld_issue_rdy));
    a_exu_waw: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_if.exu_wb_req && (wb_if.exu_wb_addr == wb_if.hzd_rd_addr)) |-> !wb_if.hzd_rd);
    a_ret_has_entry: assert property (@(posedge clk) disable iff (!rst_n)
        wb_if.ld_ret_vld |-> w_fill_ok)
        else $warning("scr1_pipe_wb_arb: load return with no outstanding entry dropped");
`endif

endmodule
`default_nettype wire

// File: tb/tb_scr1_pipe_wb_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scr1_pipe_wb_arb : scoreboard bench for the write-back arbiter        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_scr1_pipe_wb_arb;
    localparam int XLEN     = 32;
    localparam int ADDR_W   = 5;
    localparam int LD_DEPTH = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [XLEN-1:0]   d;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    wr_t  sb[$];

    always #5 clk = ~clk;

    scr1_pipe_wb_arb_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    scr1_pipe_wb_arb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .LD_DEPTH(LD_DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb_if (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hzd(input string tag, input logic e);
        check({tag, "_rs1"}, 64'(bus.hzd_rs1), 64'(e));
        check({tag, "_rs2"}, 64'(bus.hzd_rs2), 64'(e));
        check({tag, "_rd"},  64'(bus.hzd_rd),  64'(e));
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic set_q(input logic [ADDR_W-1:0] a);
        bus.hzd_rs1_addr = a;
        bus.hzd_rs2_addr = a;
        bus.hzd_rd_addr  = a;
    endtask

    task automatic exu(input logic req, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
        bus.exu_wb_req  = req;
        bus.exu_wb_addr = a;
        bus.exu_wb_data = d;
        if (req) sb.push_back('{a: a, d: d});
    endtask

    task automatic issue(input logic v, input logic [ADDR_W-1:0] a);
        bus.ld_issue      = v;
        bus.ld_issue_addr = a;
    endtask

    task automatic ret(input logic v, input logic [XLEN-1:0] d, input logic e);
        bus.ld_ret_vld  = v;
        bus.ld_ret_data = d;
        bus.ld_ret_err  = e;
    endtask

    // Every MPRF write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus.mprf_w_req === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_wr", 64'(bus.mprf_w_req), 64'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 64'(bus.mprf_rd_addr), 64'(e.a));
                check("wr_data", 64'(bus.mprf_rd_data), 64'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [XLEN-1:0] d1, d2;
        exu(1'b0, '0, '0);
        issue(1'b0, '0);
        ret(1'b0, '0, 1'b0);
        set_q('0);

        // Reset state
        to_neg();
        check("rst_rdy",   64'(bus.ld_issue_rdy), 64'd1);
        check("rst_wreq",  64'(bus.mprf_w_req),   64'd0);
        check("rst_waddr", 64'(bus.mprf_rd_addr), 64'd0);
        check("rst_wdata", 64'(bus.mprf_rd_data), 64'd0);
        chk_hzd("rst_hzd", 1'b0);
        to_pos();
        rst_n = 1'b1;
        to_pos();

        // EXU-only write
        exu(1'b1, 5'd5, 32'hA5A5_0001);
        to_neg();
        check("t1_wreq", 64'(bus.mprf_w_req), 64'd1);
        to_pos();
        exu(1'b0, '0, '0);

        // Load bypass
        set_q(5'd7);
        issue(1'b1, 5'd7);
        to_neg(); chk_hzd("t2_c0", 1'b0); to_pos();
        issue(1'b0, '0);
        to_neg(); chk_hzd("t2_c1", 1'b1); to_pos();
        ret(1'b1, 32'h0000_1234, 1'b0);
        sb.push_back('{a: 5'd7, d: 32'h0000_1234});
        to_neg(); chk_hzd("t2_c2", 1'b1); to_pos();
        ret(1'b0, '0, 1'b0);
        to_neg(); chk_hzd("t2_c3", 1'b0); to_pos();

        // Load return colliding with EXU write
        set_q(5'd3);
        issue(1'b1, 5'd3);
        to_neg(); to_pos();
        issue(1'b0, '0);
        to_neg(); to_pos();
        exu(1'b1, 5'd4, 32'h0000_4444);
        ret(1'b1, 32'h0000_BEEF, 1'b0);
        sb.push_back('{a: 5'd3, d: 32'h0000_BEEF});
        to_neg(); chk_hzd("t3_ret", 1'b1); to_pos();
        exu(1'b0, '0, '0);
        ret(1'b0, '0, 1'b0);
        to_neg(); chk_hzd("t3_wr", 1'b1); to_pos();
        to_neg(); chk_hzd("t3_done", 1'b0); to_pos();

        // Full table, deferred in-order writes, pointer wrap
        for (int r = 0; r < 5; r++) begin
            d1 = $urandom;
            d2 = $urandom;
            set_q(5'd1);
            issue(1'b1, 5'd1);
            to_neg(); check("t4_rdy_c0", 64'(bus.ld_issue_rdy), 64'd1); to_pos();
            issue(1'b1, 5'd2);
            to_neg(); to_pos();
            issue(1'b0, '0);
            exu(1'b1, 5'd20, $urandom);
            ret(1'b1, d1, 1'b0);
            to_neg(); check("t4_rdy_full", 64'(bus.ld_issue_rdy), 64'd0); to_pos();
            exu(1'b1, 5'd20, $urandom);
            ret(1'b1, d2, 1'b0);
            to_neg(); to_pos();
            exu(1'b1, 5'd20, $urandom);
            ret(1'b0, '0, 1'b0);
            sb.push_back('{a: 5'd1, d: d1});
            sb.push_back('{a: 5'd2, d: d2});
            to_neg(); chk_hzd("t4_busy", 1'b1); to_pos();
            exu(1'b0, '0, '0);
            to_neg(); check("t4_rdy_wr1", 64'(bus.ld_issue_rdy), 64'd0); to_pos();
            set_q(5'd2);
            to_neg();
            check("t4_rdy_wr2", 64'(bus.ld_issue_rdy), 64'd1);
            chk_hzd("t4_x2_pend", 1'b1);
            to_pos();
            to_neg(); chk_hzd("t4_x2_done", 1'b0); to_pos();
        end

        // Faulted load and load to x0
        set_q(5'd9);
        issue(1'b1, 5'd9);
        to_neg(); to_pos();
        issue(1'b0, '0);
        to_neg(); chk_hzd("t5_err_pend", 1'b1); to_pos();
        ret(1'b1, 32'hDEAD_0009, 1'b1);
        to_neg(); chk_hzd("t5_err_ret", 1'b1); to_pos();
        ret(1'b0, '0, 1'b0);
        to_neg(); chk_hzd("t5_err_done", 1'b0); to_pos();
        set_q(5'd0);
        issue(1'b1, 5'd0);
        to_neg(); to_pos();
        issue(1'b0, '0);
        to_neg(); chk_hzd("t5_x0", 1'b0); to_pos();
        ret(1'b1, 32'h0000_0077, 1'b0);
        to_neg(); to_pos();
        ret(1'b0, '0, 1'b0);
        set_q(5'd12);
        issue(1'b1, 5'd12);
        to_neg(); to_pos();
        issue(1'b1, 5'd13);
        to_neg(); check("t5_x0_freed", 64'(bus.ld_issue_rdy), 64'd1); to_pos();
        issue(1'b0, '0);
        to_neg();
        check("t6_rdy_full", 64'(bus.ld_issue_rdy), 64'd0);
        chk_hzd("t6_pend", 1'b1);

        // Reset with two loads pending
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rdy",  64'(bus.ld_issue_rdy), 64'd1);
        check("t6_rst_wreq", 64'(bus.mprf_w_req),   64'd0);
        chk_hzd("t6_rst", 1'b0);
        to_neg();
        to_pos();
        rst_n = 1'b1;
        ret(1'b1, 32'h0000_5555, 1'b0);
        to_neg(); check("t6_stray_wreq", 64'(bus.mprf_w_req), 64'd0); to_pos();
        ret(1'b0, '0, 1'b0);
        to_neg();
        check("t6_after_rdy", 64'(bus.ld_issue_rdy), 64'd1);
        chk_hzd("t6_after", 1'b0);
        to_pos();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
